// File: rtl/axi_stream_frame_sequencer_if.sv
// AXI4-Stream bundle for the frame sequencer; the slave side carries only
// what the upstream pin source provides (no TLAST/TDEST/TKEEP).
interface axi_stream_frame_sequencer_if;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tlast;
  logic [1:0]  tdest;
  logic [3:0]  tkeep;

  modport master (output tvalid, tdata, tlast, tdest, tkeep, input tready);
  modport slave  (input tvalid, tdata, output tready);
endinterface

// File: rtl/axi_stream_frame_sequencer.sv
// Cuts a continuous 32-bit stream into DMA frames with TLAST, round-robin TDEST
// and inter-frame gaps. Optional FRAME_SEQ_HEADER_EN prepends a header beat per frame.
module axi_stream_frame_sequencer #(
  parameter int LEN_BITS = 16,
  parameter int NUM_DEST = 4,
  parameter int GAP_BITS = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [LEN_BITS-1:0]  cfg_frame_len,
  input  logic [LEN_BITS-1:0]  cfg_num_frames,
  input  logic [GAP_BITS-1:0]  cfg_gap,
  axi_stream_frame_sequencer_if.slave  s_axis,
  axi_stream_frame_sequencer_if.master m_axis,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_BITS-1:0]  frames_sent,
  output logic                 err_len_zero
);

`ifdef FRAME_SEQ_HEADER_EN
  typedef enum logic [2:0] {IDLE, STREAM, GAP, ABORT, HEADER} state_t;
  localparam state_t FRAME_ENTRY = HEADER;
`else
  typedef enum logic [2:0] {IDLE, STREAM, GAP, ABORT} state_t;
  localparam state_t FRAME_ENTRY = STREAM;
`endif

  state_t state, state_nxt;

  logic [LEN_BITS-1:0] len_q, num_q, beat_cnt;
  logic [GAP_BITS-1:0] gap_q, gap_cnt;
  logic [1:0]          tdest;
  logic                open, beat, last_frame;
  logic                start_ok, err_nxt, frame_end, fin;

  // ABORT keeps the datapath open so the forced-TLAST beat can close the frame
  assign open = (state == STREAM) || (state == ABORT);

`ifdef FRAME_SEQ_HEADER_EN
  logic        hdr_abort;
  logic [15:0] fs16;
  assign fs16          = 16'(frames_sent);
  assign m_axis.tvalid = (s_axis.tvalid & open) | (state == HEADER);
  assign m_axis.tdata  = (state == HEADER) ? {8'hA5, 6'b0, tdest, fs16} : s_axis.tdata;
`else
  assign m_axis.tvalid = s_axis.tvalid & open;
  assign m_axis.tdata  = s_axis.tdata;
`endif

  assign s_axis.tready = m_axis.tready & open;
  assign m_axis.tlast  = (state == ABORT) ||
                         ((state == STREAM) && (beat_cnt == len_q - 1'b1));
  assign m_axis.tdest  = tdest;
  assign m_axis.tkeep  = 4'hF;

  assign beat       = m_axis.tvalid & m_axis.tready;
  assign last_frame = (num_q != '0) && (frames_sent + 1'b1 == num_q);

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    err_nxt   = 1'b0;
    frame_end = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE:
        if (cfg_start) begin
          if (cfg_frame_len != '0) begin
            start_ok  = 1'b1;
            state_nxt = FRAME_ENTRY;
          end else begin
            err_nxt = 1'b1;
          end
        end
      STREAM:
        if (beat && m_axis.tlast) begin
          frame_end = 1'b1;
          if (last_frame || cfg_abort) begin
            fin       = 1'b1;
            state_nxt = IDLE;
          end else if (gap_q != '0) begin
            state_nxt = GAP;
          end else begin
            state_nxt = FRAME_ENTRY;
          end
        end else if (cfg_abort) begin
          // a frame whose first beat is leaving now is already open downstream
          if (beat_cnt != '0 || beat) state_nxt = ABORT;
          else begin
            fin       = 1'b1;
            state_nxt = IDLE;
          end
        end
      GAP:
        if (cfg_abort) begin
          fin       = 1'b1;
          state_nxt = IDLE;
        end else if (gap_cnt == gap_q - 1'b1) begin
          state_nxt = FRAME_ENTRY;
        end
      ABORT:
        if (beat) begin
          frame_end = 1'b1;
          fin       = 1'b1;
          state_nxt = IDLE;
        end
`ifdef FRAME_SEQ_HEADER_EN
      HEADER:
        if (beat) state_nxt = (cfg_abort || hdr_abort) ? ABORT : STREAM;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      len_q        <= '0;
      num_q        <= '0;
      gap_q        <= '0;
      beat_cnt     <= '0;
      gap_cnt      <= '0;
      tdest        <= '0;
      frames_sent  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_len_zero <= 1'b0;
    end else begin
      done         <= fin;
      err_len_zero <= err_nxt;
      gap_cnt      <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (start_ok) begin
        len_q       <= cfg_frame_len;
        num_q       <= cfg_num_frames;
        gap_q       <= cfg_gap;
        frames_sent <= '0;
        beat_cnt    <= '0;
        tdest       <= '0;
        busy        <= 1'b1;
      end
      if (fin) busy <= 1'b0;
      if (beat && state == STREAM)
        beat_cnt <= m_axis.tlast ? '0 : beat_cnt + 1'b1;
      if (beat && state == ABORT)
        beat_cnt <= '0;
      if (frame_end) begin
        frames_sent <= frames_sent + 1'b1;
        tdest       <= (tdest == 2'(NUM_DEST - 1)) ? 2'd0 : tdest + 2'd1;
      end
    end
  end

`ifdef FRAME_SEQ_HEADER_EN
  // remembers an abort that arrived while the header was stalled
  always_ff @(posedge aclk) begin
    if (!aresetn) hdr_abort <= 1'b0;
    else          hdr_abort <= (state == HEADER) && (hdr_abort || cfg_abort) && !beat;
  end
`endif

endmodule
